// File: rtl/packet_sink_if.sv
// packet_sink_if: router output channel (flit in) and credit return (flow control out) for one sink port.
// Latency: none, wires only; credits are registered inside the sink.
// Backpressure: none on the flit path; the credit channel is the only flow control back to the router.
//
// Signals:
//   chan_vld/chan_vc/chan_head/chan_tail/chan_dat : incoming flit {valid, vc_idx, head, tail, data}
//   credit_vld/credit_vc                          : credit return {valid, vc_idx}
// Modports: master = router side, slave = sink side.
interface packet_sink_if #(
    parameter int num_vcs         = 4,
    parameter int flit_data_width = 64
);
    localparam int VW = $clog2(num_vcs);

    logic                       chan_vld;
    logic [VW-1:0]              chan_vc;
    logic                       chan_head;
    logic                       chan_tail;
    logic [flit_data_width-1:0] chan_dat;

    logic                       credit_vld;
    logic [VW-1:0]              credit_vc;

    modport master (
        output chan_vld, chan_vc, chan_head, chan_tail, chan_dat,
        input  credit_vld, credit_vc
    );

    modport slave (
        input  chan_vld, chan_vc, chan_head, chan_tail, chan_dat,
        output credit_vld, credit_vc
    );
endinterface

// File: rtl/packet_sink.sv
// packet_sink: receive endpoint for one router output port; per-VC occupancy, framing check, credit return.
// Latency: a flit is poppable the edge after it is stored; its credit is visible the cycle after the pop edge.
// Backpressure: none upstream; a flit to a full VC is dropped and raises the sticky error.
//
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   link (slave)   : flit input channel and credit return channel
//   packet_count   : completed packets (accepted tails), wraps
//   vc_busy        : per-VC open-packet flag (head seen, tail not yet)
//   error          : sticky framing / overflow error
//   flit_count, max_occupancy : only when PACKET_SINK_STATS_EN is defined
//
// Drains are attempted when (lfsr mod 100) < consume_rate, using a 32-bit Galois LFSR
// (left shift, feedback mask 0x80200003 applied when the bit shifted out is 1).
module packet_sink #(
    parameter logic [31:0] initial_seed           = 32'd0,
    parameter int          consume_rate           = 50,
    parameter int          num_vcs                = 4,
    parameter int          buffer_size            = 16,
    parameter int          flit_data_width        = 64,
    parameter int          packet_count_reg_width = 32
) (
    input  logic                                     clk,
    input  logic                                     reset,
    packet_sink_if.slave                             link,
    output logic [packet_count_reg_width-1:0]        packet_count,
    output logic [num_vcs-1:0]                       vc_busy,
    output logic                                     error
`ifdef PACKET_SINK_STATS_EN
    ,
    output logic [31:0]                              flit_count,
    output logic [$clog2(buffer_size/num_vcs+1)-1:0] max_occupancy
`endif
);

    localparam int              DEPTH = buffer_size / num_vcs;
    localparam int              VW    = $clog2(num_vcs);
    localparam int              CW    = $clog2(DEPTH + 1);
    localparam int              PCW   = packet_count_reg_width;
    localparam logic [31:0]     SEED  = (initial_seed == 32'd0) ? 32'd1 : initial_seed;
    localparam logic [31:0]     POLY  = 32'h8020_0003;
    localparam logic [31:0]     RATE  = 32'(consume_rate);
    localparam logic [CW-1:0]   FULL  = CW'(DEPTH);

    logic [31:0]                lfsr;
    logic                       drain_en;
    logic [CW-1:0]              occ      [num_vcs];
    logic [CW-1:0]              occ_next [num_vcs];
    logic [VW-1:0]              rr_ptr;
    logic                       pop_vld;
    logic [VW-1:0]              pop_vc;
    logic [VW-1:0]              in_vc;
    logic                       push_ovf;
    logic                       push_ok;
    logic                       frame_err;
    logic [flit_data_width-1:0] chan_dat;
    logic                       unused_dat;

    // Buffered flits are only ever counted and popped, never read back, so each VC
    // queue reduces to its occupancy counter. Payload is not inspected at all.
    assign chan_dat   = link.chan_dat;
    assign unused_dat = ^chan_dat;

    assign drain_en = (lfsr % 32'd100) < RATE;

    // Round-robin pick starting at rr_ptr. Scanning from the farthest offset down
    // lets the nearest non-empty VC overwrite the others. Index arithmetic wraps
    // naturally because num_vcs is a power of two.
    always_comb begin
        pop_vld = 1'b0;
        pop_vc  = rr_ptr;
        for (int i = num_vcs - 1; i >= 0; i--) begin
            if (drain_en && (occ[rr_ptr + VW'(i)] != '0)) begin
                pop_vld = 1'b1;
                pop_vc  = rr_ptr + VW'(i);
            end
        end
    end

    // Overflow is judged on the pre-edge count, so a same-cycle pop does not
    // make room. A dropped flit touches neither occupancy nor framing state.
    assign in_vc    = link.chan_vc;
    assign push_ovf = link.chan_vld && (occ[in_vc] == FULL);
    assign push_ok  = link.chan_vld && !push_ovf;

    // Legal only as head-on-idle or non-head-on-busy: any flit whose head bit
    // equals the VC's busy flag is a framing violation.
    assign frame_err = push_ok && (link.chan_head == vc_busy[in_vc]);

    always_comb begin
        for (int v = 0; v < num_vcs; v++) begin
            occ_next[v] = occ[v];
            case ({push_ok && (in_vc == VW'(v)), pop_vld && (pop_vc == VW'(v))})
                2'b10:   occ_next[v] = occ[v] + CW'(1);
                2'b01:   occ_next[v] = occ[v] - CW'(1);
                default: occ_next[v] = occ[v];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr            <= SEED;
            rr_ptr          <= '0;
            for (int v = 0; v < num_vcs; v++) begin
                occ[v] <= '0;
            end
            vc_busy         <= '0;
            packet_count    <= '0;
            error           <= 1'b0;
            link.credit_vld <= 1'b0;
            link.credit_vc  <= '0;
        end else begin
            lfsr <= lfsr[31] ? ({lfsr[30:0], 1'b0} ^ POLY) : {lfsr[30:0], 1'b0};
            for (int v = 0; v < num_vcs; v++) begin
                occ[v] <= occ_next[v];
            end

            link.credit_vld <= pop_vld;
            if (pop_vld) begin
                link.credit_vc <= pop_vc;
                rr_ptr         <= pop_vc + VW'(1);
            end

            // A tail always closes the packet, even when it also flagged an error.
            if (push_ok) begin
                if (link.chan_tail) begin
                    vc_busy[in_vc] <= 1'b0;
                    packet_count   <= packet_count + PCW'(1);
                end else if (link.chan_head) begin
                    vc_busy[in_vc] <= 1'b1;
                end
            end

            if (push_ovf || frame_err) begin
                error <= 1'b1;
            end
        end
    end

`ifdef PACKET_SINK_STATS_EN
    logic [CW-1:0] occ_peak;

    always_comb begin
        occ_peak = '0;
        for (int v = 0; v < num_vcs; v++) begin
            if (occ_next[v] > occ_peak) begin
                occ_peak = occ_next[v];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_count    <= '0;
            max_occupancy <= '0;
        end else begin
            if (push_ok) begin
                flit_count <= flit_count + 32'd1;
            end
            if (occ_peak > max_occupancy) begin
                max_occupancy <= occ_peak;
            end
        end
    end
`endif

endmodule

// File: tb/tb_packet_sink.sv
// tb_packet_sink: three sinks (consume_rate 0, 50, 100) share one flit stream.
// A queue-level model per sink is compared on every negedge; directed steps add literal expectations.
module tb_packet_sink;
    localparam int NV  = 4;
    localparam int DW  = 64;
    localparam int BUF = 16;
    localparam int D   = BUF / NV;
    localparam int NK  = 3;
    localparam int RATES [NK] = '{0, 50, 100};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_vld;
    logic [1:0]    s_vc;
    logic          s_head;
    logic          s_tail;
    logic [DW-1:0] s_dat;

    logic          d_cvld [NK];
    logic [1:0]    d_cvc  [NK];
    logic [31:0]   d_pkt  [NK];
    logic [NV-1:0] d_busy [NK];
    logic          d_err  [NK];
`ifdef PACKET_SINK_STATS_EN
    logic [31:0]   d_flits  [NK];
    logic [2:0]    d_maxocc [NK];
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        packet_sink_if #(.num_vcs(NV), .flit_data_width(DW)) link ();

        assign link.chan_vld  = s_vld;
        assign link.chan_vc   = s_vc;
        assign link.chan_head = s_head;
        assign link.chan_tail = s_tail;
        assign link.chan_dat  = s_dat;
        assign d_cvld[g]      = link.credit_vld;
        assign d_cvc[g]       = link.credit_vc;

        packet_sink #(
            .initial_seed           (32'd0),
            .consume_rate           (RATES[g]),
            .num_vcs                (NV),
            .buffer_size            (BUF),
            .flit_data_width        (DW),
            .packet_count_reg_width (32)
        ) u_dut (
            .clk           (clk),
            .reset         (rst_n),
            .link          (link),
            .packet_count  (d_pkt[g]),
            .vc_busy       (d_busy[g]),
            .error         (d_err[g])
`ifdef PACKET_SINK_STATS_EN
            ,
            .flit_count    (d_flits[g]),
            .max_occupancy (d_maxocc[g])
`endif
        );
    end

    // ---------------- behavioural model ----------------
    bit [31:0]     m_lfsr [NK];
    int            m_occ  [NK][NV];
    bit [NV-1:0]   m_busy [NK];
    bit [31:0]     m_pkt  [NK];
    bit            m_err  [NK];
    int            m_ptr  [NK];
    bit            m_cvld [NK];
    int            m_cvc  [NK];
    bit [31:0]     m_flits  [NK];
    int            m_maxocc [NK];

    function automatic bit [31:0] lfsr_step(input bit [31:0] x);
        bit [31:0] y;
        y = x << 1;
        if (x[31]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    task automatic model_reset(input int k);
        m_lfsr[k] = 32'd1;
        for (int v = 0; v < NV; v++) m_occ[k][v] = 0;
        m_busy[k]   = '0;
        m_pkt[k]    = '0;
        m_err[k]    = 1'b0;
        m_ptr[k]    = 0;
        m_cvld[k]   = 1'b0;
        m_cvc[k]    = 0;
        m_flits[k]  = '0;
        m_maxocc[k] = 0;
    endtask

    task automatic model_step(input int k);
        int pv;
        int vc;
        pv = -1;
        vc = int'(s_vc);
        if ((m_lfsr[k] % 100) < RATES[k]) begin
            for (int i = 0; i < NV; i++) begin
                if (pv < 0 && m_occ[k][(m_ptr[k] + i) % NV] > 0) pv = (m_ptr[k] + i) % NV;
            end
        end
        if (s_vld === 1'b1) begin
            if (m_occ[k][vc] == D) begin
                m_err[k] = 1'b1;
            end else begin
                m_occ[k][vc] = m_occ[k][vc] + 1;
                m_flits[k]   = m_flits[k] + 1;
                if (s_head && m_busy[k][vc]) m_err[k] = 1'b1;
                if (!s_head && !m_busy[k][vc]) m_err[k] = 1'b1;
                if (s_tail) begin
                    m_busy[k][vc] = 1'b0;
                    m_pkt[k]      = m_pkt[k] + 1;
                end else if (s_head) begin
                    m_busy[k][vc] = 1'b1;
                end
            end
        end
        if (pv >= 0) begin
            m_occ[k][pv] = m_occ[k][pv] - 1;
            m_ptr[k]     = (pv + 1) % NV;
            m_cvld[k]    = 1'b1;
            m_cvc[k]     = pv;
        end else begin
            m_cvld[k] = 1'b0;
        end
        for (int v = 0; v < NV; v++) begin
            if (m_occ[k][v] > m_maxocc[k]) m_maxocc[k] = m_occ[k][v];
        end
        m_lfsr[k] = lfsr_step(m_lfsr[k]);
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NK; k++) begin
            if (!rst_n) model_reset(k);
            else        model_step(k);
        end
    end

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (rate %0d) at %0t: got %0h expected %0h", name, RATES[k], $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            check("credit_vld",   k, 64'(d_cvld[k]), 64'(m_cvld[k]));
            check("credit_vc",    k, 64'(d_cvc[k]),  64'(m_cvc[k]));
            check("packet_count", k, 64'(d_pkt[k]),  64'(m_pkt[k]));
            check("vc_busy",      k, 64'(d_busy[k]), 64'(m_busy[k]));
            check("error",        k, 64'(d_err[k]),  64'(m_err[k]));
`ifdef PACKET_SINK_STATS_EN
            check("flit_count",    k, 64'(d_flits[k]),  64'(m_flits[k]));
            check("max_occupancy", k, 64'(d_maxocc[k]), 64'(m_maxocc[k]));
`endif
        end
    end

    // Credit recorder for the always-draining sink.
    int rec_q[$];
    bit rec_en = 1'b0;
    always @(negedge clk) begin
        if (rec_en && d_cvld[2] === 1'b1) rec_q.push_back(int'(d_cvc[2]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        s_vld  = 1'b0;
        s_head = 1'b0;
        s_tail = 1'b0;
    endtask

    task automatic send(input int vc, input bit h, input bit t);
        s_vld  = 1'b1;
        s_vc   = 2'(vc);
        s_head = h;
        s_tail = t;
        s_dat  = {$urandom, $urandom};
        @(negedge clk);
        drive_idle();
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(negedge clk);
    endtask

    // Reset with random channel activity; outputs must stay cleared throughout.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s_vld  = 1'($urandom_range(0, 1));
            s_vc   = 2'($urandom_range(0, 3));
            s_head = 1'($urandom_range(0, 1));
            s_tail = 1'($urandom_range(0, 1));
            s_dat  = {$urandom, $urandom};
            @(negedge clk);
            for (int k = 0; k < NK; k++) begin
                check("rst_credit_vld", k, 64'(d_cvld[k]), 64'd0);
                check("rst_credit_vc",  k, 64'(d_cvc[k]),  64'd0);
                check("rst_pkt",        k, 64'(d_pkt[k]),  64'd0);
                check("rst_err",        k, 64'(d_err[k]),  64'd0);
                check("rst_busy",       k, 64'(d_busy[k]), 64'd0);
            end
        end
        drive_idle();
        rst_n = 1'b1;
    endtask

    bit [31:0] lx;

    initial begin
        rst_n = 1'b0;
        s_vc  = '0;
        s_dat = '0;
        drive_idle();

        // Pin the model's LFSR: 1 shifts to bit 31 after 31 steps, then feeds back the mask.
        lx = 32'd1;
        for (int i = 0; i < 5; i++) lx = lfsr_step(lx);
        check("model_lfsr_5", 0, 64'(lx), 64'd32);
        for (int i = 5; i < 32; i++) lx = lfsr_step(lx);
        check("model_lfsr_32", 0, 64'(lx), 64'h8020_0003);

        // Reset, then no credit before any flit.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < NK; k++) check("idle_no_credit", k, 64'(d_cvld[k]), 64'd0);
        end

        // Single-flit packet on VC2: stored at edge A, popped at A+1, credit in the cycle after.
        send(2, 1'b1, 1'b1);
        check("sf_pkt",         2, 64'(d_pkt[2]),  64'd1);
        check("sf_no_credit_a", 2, 64'(d_cvld[2]), 64'd0);
        check("sf_busy",        2, 64'(d_busy[2]), 64'd0);
        idle(1);
        check("sf_credit_vld",  2, 64'(d_cvld[2]), 64'd1);
        check("sf_credit_vc",   2, 64'(d_cvc[2]),  64'd2);
        idle(1);
        check("sf_credit_drop", 2, 64'(d_cvld[2]), 64'd0);
        check("sf_vc_held",     2, 64'(d_cvc[2]),  64'd2);
        check("sf_err",         2, 64'(d_err[2]),  64'd0);

        // 4-flit packet on VC1 into the never-draining sink.
        send(1, 1'b1, 1'b0);
        check("mf_busy_head", 0, 64'(d_busy[0][1]), 64'd1);
        send(1, 1'b0, 1'b0);
        send(1, 1'b0, 1'b0);
        check("mf_busy_body", 0, 64'(d_busy[0][1]), 64'd1);
        send(1, 1'b0, 1'b1);
        check("mf_busy_tail", 0, 64'(d_busy[0][1]), 64'd0);
        check("mf_pkt",       0, 64'(d_pkt[0]),     64'd2);
        check("mf_no_credit", 0, 64'(d_cvld[0]),    64'd0);
        check("mf_err",       0, 64'(d_err[0]),     64'd0);

        // Overflow: fifth flit into a full VC0 is dropped and flagged.
        do_reset();
        send(0, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        check("ovf_err_4", 0, 64'(d_err[0]), 64'd0);
        send(0, 1'b0, 1'b0);
        check("ovf_err_5",   0, 64'(d_err[0]), 64'd1);
        check("ovf_r100_ok", 2, 64'(d_err[2]), 64'd0);
        send(0, 1'b0, 1'b1);
        check("ovf_tail_dropped_pkt",  0, 64'(d_pkt[0]),     64'd0);
        check("ovf_tail_dropped_busy", 0, 64'(d_busy[0][0]), 64'd1);
        check("ovf_r100_pkt",          2, 64'(d_pkt[2]),     64'd1);
        check("ovf_r100_busy",         2, 64'(d_busy[2][0]), 64'd0);

        // Framing: body on idle VC3; then double head on VC0.
        do_reset();
        send(3, 1'b0, 1'b0);
        for (int k = 0; k < NK; k++) check("frm_body_idle", k, 64'(d_err[k]), 64'd1);
        do_reset();
        send(0, 1'b1, 1'b0);
        for (int k = 0; k < NK; k++) check("frm_first_head", k, 64'(d_err[k]), 64'd0);
        send(0, 1'b1, 1'b0);
        for (int k = 0; k < NK; k++) check("frm_double_head", k, 64'(d_err[k]), 64'd1);

        // Round-robin order: two single-flit packets per VC, VC0..VC3 twice.
        do_reset();
        rec_q.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 8; i++) send(i % NV, 1'b1, 1'b1);
        idle(10);
        rec_en = 1'b0;
        check("rr_credit_total", 2, 64'(rec_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < rec_q.size(); i++) check("rr_order", 2, 64'(rec_q[i]), 64'(i % NV));
        check("rr_r0_pkt",  0, 64'(d_pkt[0]),  64'd8);
        check("rr_r0_busy", 0, 64'(d_busy[0]), 64'd0);

        // Rate-50 gate from seed 1: lfsr 1,2,4,8,16,32,64,128 -> drains allowed except at value 64.
        do_reset();
        send(0, 1'b1, 1'b1);
        check("gate_a_none", 1, 64'(d_cvld[1]), 64'd0);
        idle(1);
        check("gate_a_vld", 1, 64'(d_cvld[1]), 64'd1);
        check("gate_a_vc",  1, 64'(d_cvc[1]),  64'd0);
        idle(3);
        send(1, 1'b1, 1'b1);
        idle(1);
        check("gate_b_blocked", 1, 64'(d_cvld[1]), 64'd0);
        idle(1);
        check("gate_b_vld", 1, 64'(d_cvld[1]), 64'd1);
        check("gate_b_vc",  1, 64'(d_cvc[1]),  64'd1);

        // Flood VC0 then spread traffic; the per-cycle model covers the rest.
        do_reset();
        send(0, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b1);
        check("flood_r100_pkt", 2, 64'(d_pkt[2]), 64'd1);
        check("flood_r100_err", 2, 64'(d_err[2]), 64'd0);
        check("flood_r0_err",   0, 64'(d_err[0]), 64'd1);
        idle(60);
        for (int c = 0; c < 300; c++) begin
            s_vld  = ($urandom_range(0, 3) != 0);
            s_vc   = 2'($urandom_range(0, 3));
            s_head = 1'($urandom_range(0, 1));
            s_tail = 1'($urandom_range(0, 1));
            s_dat  = {$urandom, $urandom};
            @(negedge clk);
        end
        idle(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/packet_sink.md
Name: packet_sink

Overview:
- Receive-side endpoint for one router output port: the counterpart of the packet source that drives router inputs.
- Accepts flits from a router output channel and tracks per-VC buffer occupancy.
- Drains flits at a programmable pseudo-random rate and returns one credit per drained flit on the flow-control channel.
- Checks head/tail framing per VC, counts completed packets and raises a sticky error on protocol violations.

Parameters:
- initial_seed, 0, LFSR seed for the consumption gate (zero seed replaced by 1).
- consume_rate, 50, percentage of cycles a drain is attempted (0..100).
- num_vcs, 4, number of virtual channels (power of two, >=2).
- buffer_size, 16, total flit slots; per-VC depth = buffer_size/num_vcs (>=2).
- flit_data_width, 64, flit payload width.
- packet_count_reg_width, 32, width of packet counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- channel  input  3+clogb(num_vcs)+flit_data_width  incoming flit, fields in order {valid, vc_idx, head, tail, data}.
- flow_ctrl  output  1+clogb(num_vcs)  credit return {valid, vc_idx}.
- packet_count  output  packet_count_reg_width  completed packets (tail accepted).
- vc_busy  output  num_vcs  bit set while a VC holds an open packet (head seen, tail not yet).
- error  output  1  sticky protocol error.

Behaviour:
- Reset (reset low, asynchronous) clears: occupancy counters, per-VC head/tail queues, vc_busy, packet_count, flow_ctrl (valid=0, vc=0), error, round-robin pointer (VC 0). LFSR loads the seed.
- Per VC there is a FIFO of depth D = buffer_size/num_vcs. Each entry stores only {head, tail}; data is ignored.
- Write: channel.valid=1 pushes {head, tail} into FIFO[vc_idx] at the clock edge.
- Framing, per VC, tracked by vc_busy at arrival:
  - Head with vc_busy=0: sets vc_busy.
  - Head with vc_busy=1: error.
  - Non-head with vc_busy=0: error.
  - Tail clears vc_busy and increments packet_count.
  - A head+tail flit (single-flit packet) leaves vc_busy=0 and increments packet_count.
- Overflow: a flit arriving to a full FIFO (count == D) sets error. The flit is dropped and no count changes.
- Drain gate: 32-bit Galois LFSR (polynomial 0x80200003) advances every cycle. Drain is enabled when (lfsr mod 100) < consume_rate. consume_rate=100 always drains; 0 never drains.
- Drain selection: round-robin among non-empty FIFOs, starting at the pointer. The pointer advances to the granted VC + 1 (mod num_vcs). At most one pop per cycle.
- Credit: a pop at edge N drives flow_ctrl = {1, vc} during cycle N+1 (registered, 1-cycle latency). Otherwise flow_ctrl.valid=0 and vc holds its last value.
- Simultaneous push and pop on the same VC: count unchanged. A full FIFO with a same-cycle pop still overflows; the pop is evaluated on pre-edge state.
- Occupancy counters are clogb(D+1) bits and never wrap. Underflow cannot occur because pops only happen from non-empty FIFOs.
- packet_count wraps modulo 2^packet_count_reg_width.
- error is sticky until reset.
- Reset asserted mid-packet: all state is cleared immediately. The first post-reset non-head flit raises error.

Optional Feature:
- Macro PACKET_SINK_STATS_EN.
- Defined: adds output flit_count (32 bits), counting every accepted (non-dropped) flit, wrapping, cleared by reset. Also adds output max_occupancy (clogb(D+1) bits), the high-water mark of any single VC FIFO count.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset check: reset low with random channel activity -> flow_ctrl=0, packet_count=0, error=0, vc_busy=0 throughout. After release, no credit appears until a flit arrives.
- Single-flit packet, consume_rate=100: send head+tail on VC2 at cycle 0 -> pop at edge 1, flow_ctrl={1,2} in cycle 2, packet_count=1, error=0.
- 4-flit packet on VC1, consume_rate=0: head, body, body, tail -> vc_busy[1] is high from head to tail. No credits are returned. packet_count=1 after tail. Occupancy reaches 4 of D=4.
- Overflow: consume_rate=0, D=4, send 5 flits on VC0 -> error=1 on the 5th. The 5th flit is not stored: switching to rate 100 yields exactly 4 credits.
- Framing errors: body flit on idle VC3 -> error=1. After a fresh reset, two heads on VC0 with no tail -> error=1.
- Round-robin fairness: fill VC0..VC3 with 2 flits each, then consume_rate=100 -> credit VC order 0,1,2,3,0,1,2,3. Exactly 8 credits total.
